// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and default sizing for the SPI transfer controller.
//             Holds the controller state encoding and the default frame width
//             and SCLK divider used when the top is instantiated bare.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_STORE  = 3'd4,
    ST_FINISH = 3'd5
  } spi_state_e;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_clk_gen
//  Purpose  : SPI mode-0 clock generator. While enabled, toggles sclk every
//             CLK_DIV clk cycles, starting from low. The rise/fall strobes are
//             high in the clk cycle whose closing edge makes sclk go high/low,
//             so logic clocked on that same edge samples/shifts in step with
//             the visible SCLK edge. Disabling parks sclk low and clears the
//             divider so the next enable starts a fresh half-period.
//  Ports    : clk   in  system clock
//             rst_n in  synchronous active-low reset
//             en    in  run the divider
//             sclk  out SPI clock (idle low)
//             rise  out one-cycle strobe: sclk rises at the next clk edge
//             fall  out one-cycle strobe: sclk falls at the next clk edge
//  Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          half_done;

  assign half_done = en && (div_cnt == CNT_LAST);
  assign rise      = half_done && !sclk;
  assign fall      = half_done &&  sclk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule : spi_clk_gen
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_ctrl
//  Purpose  : SPI master transfer controller. Moves i_len frames from a TX
//             FIFO out on MOSI (MSB first, mode 0) and writes the frames
//             received on MISO into an RX FIFO. Chip select stays low for the
//             whole transfer, including FIFO stalls between frames.
//  Ports    : i_clk, i_rst_n      clock, synchronous active-low reset
//             i_start, i_len      transfer request and frame count (1..255)
//             o_busy, o_done      activity flag, end-of-transfer pulse
//             tx_empty/tx_ren/tx_data   TX FIFO read side (1-cycle latency)
//             rx_full/rx_wen/rx_data    RX FIFO write side
//             o_sclk, o_cs_n, o_mosi, i_miso   SPI pins
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_len,
  output logic              o_busy,
  output logic              o_done,
  input  logic              tx_empty,
  output logic              tx_ren,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              rx_full,
  output logic              rx_wen,
  output logic [DWIDTH-1:0] rx_data,
  output logic              o_sclk,
  output logic              o_cs_n,
  output logic              o_mosi,
  input  logic              i_miso
);

  localparam int            BW       = $clog2(DWIDTH) + 1;
  localparam int            FW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DWIDTH - 1);
  localparam logic [FW-1:0] FIN_LAST = FW'(CLK_DIV - 1);

  spi_state_e        state;
  spi_state_e        state_nxt;

  logic              sclk_en;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              start_ok;
  logic              last_fall;
  logic              fin_last;
  logic              done_q;
  logic [BW-1:0]     bit_cnt;
  logic [7:0]        remaining;
  logic [FW-1:0]     fin_cnt;
  logic [DWIDTH-1:0] tx_sr;
  logic [DWIDTH-1:0] rx_sr;

  assign start_ok  = i_start && (i_len != 8'd0);
  // The frame ends on the DWIDTH-th falling edge, leaving SCLK low.
  assign last_fall = sclk_fall && (bit_cnt == BIT_LAST);
  assign fin_last  = (fin_cnt == FIN_LAST);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (sclk_en),
    .sclk  (o_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_ok)  state_nxt = ST_FETCH;
      ST_FETCH:  if (!tx_empty) state_nxt = ST_LOAD;
      ST_LOAD:                  state_nxt = ST_SHIFT;
      ST_SHIFT:  if (last_fall) state_nxt = ST_STORE;
      ST_STORE:  if (!rx_full)  state_nxt = (remaining == 8'd1) ? ST_FINISH : ST_FETCH;
      ST_FINISH: if (fin_last)  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    o_busy  = (state != ST_IDLE);
    o_cs_n  = (state == ST_IDLE);
    tx_ren  = (state == ST_FETCH) && !tx_empty;
    rx_wen  = (state == ST_STORE) && !rx_full;
    sclk_en = (state == ST_SHIFT);
  end

  // The done pulse is registered so it lands in the first IDLE cycle,
  // i.e. together with chip select returning high.
  assign o_done  = done_q;
  assign o_mosi  = tx_sr[DWIDTH-1];
  assign rx_data = rx_sr;

  // --------------------------------------------------------------------------
  // Datapath: shift registers and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      done_q    <= 1'b0;
      remaining <= '0;
      bit_cnt   <= '0;
      fin_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      done_q <= (state == ST_FINISH) && fin_last;
      case (state)
        ST_IDLE: begin
          if (start_ok) remaining <= i_len;
        end
        ST_LOAD: begin
          tx_sr   <= tx_data;
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          if (sclk_rise) rx_sr <= {rx_sr[DWIDTH-2:0], i_miso};
          if (sclk_fall) begin
            tx_sr   <= tx_sr << 1;
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_STORE: begin
          if (!rx_full && (remaining != 8'd0)) remaining <= remaining - 8'd1;
        end
        ST_FINISH: begin
          fin_cnt <= fin_last ? '0 : fin_cnt + FW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule : spi_xfer_ctrl
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_xfer_ctrl
//  Purpose  : Directed self-checking bench for spi_xfer_ctrl with a small TX
//             FIFO model and MOSI->MISO loopback.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;

  localparam int DW = 8;
  localparam int CD = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic [7:0]    len      = 8'd0;
  logic          rx_full  = 1'b0;
  logic [DW-1:0] tx_data  = '0;
  logic          busy, done, tx_empty, tx_ren, rx_wen;
  logic [DW-1:0] rx_data;
  logic          sclk, cs_n, mosi, miso;

  assign miso = mosi;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .DWIDTH  (DW),
    .CLK_DIV (CD)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_len    (len),
    .o_busy   (busy),
    .o_done   (done),
    .tx_empty (tx_empty),
    .tx_ren   (tx_ren),
    .tx_data  (tx_data),
    .rx_full  (rx_full),
    .rx_wen   (rx_wen),
    .rx_data  (rx_data),
    .o_sclk   (sclk),
    .o_cs_n   (cs_n),
    .o_mosi   (mosi),
    .i_miso   (miso)
  );

  // TX FIFO model: registered read data, valid the cycle after tx_ren.
  logic [7:0] tx_mem [0:15];
  int tx_wr = 0;
  int tx_rd = 0;
  assign tx_empty = (tx_wr == tx_rd);

  always @(posedge clk) begin
    if (tx_ren && !tx_empty) begin
      tx_data <= tx_mem[tx_rd % 16];
      tx_rd   <= tx_rd + 1;
    end
  end

  // Event monitor.
  int         rises   = 0;
  int         dones   = 0;
  int         wens    = 0;
  int         rens    = 0;
  int         cs_viol = 0;
  int         overlap = 0;
  logic       sclk_q  = 1'b0;
  logic [7:0] rx_log [0:31];

  always @(posedge clk) begin
    sclk_q <= sclk;
    if (sclk && !sclk_q) rises <= rises + 1;
    if (done)            dones <= dones + 1;
    if (tx_ren)          rens  <= rens + 1;
    if (rx_wen) begin
      rx_log[wens % 32] <= rx_data;
      wens              <= wens + 1;
    end
    if (busy && cs_n)    cs_viol <= cs_viol + 1;
    if (tx_ren && rx_wen) overlap <= overlap + 1;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    tx_mem[tx_wr % 16] = b;
    tx_wr++;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (dones == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_timeout", tag), 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int r0, input int target);
    int n = 0;
    while ((rises - r0) < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_timeout", tag), 32'(n < 3000), 32'd1);
  endtask

  int r0, d0, w0, n0, p0;

  initial begin
    // ---------------- reset state ----------------
    tick(3);
    check("rst_busy",   32'(busy),    32'd0);
    check("rst_cs_n",   32'(cs_n),    32'd1);
    check("rst_sclk",   32'(sclk),    32'd0);
    check("rst_mosi",   32'(mosi),    32'd0);
    check("rst_done",   32'(done),    32'd0);
    check("rst_tx_ren", 32'(tx_ren),  32'd0);
    check("rst_rx_wen", 32'(rx_wen),  32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // ---------------- loopback, two frames ----------------
    push(8'hA5); push(8'h3C);
    r0 = rises; d0 = dones; w0 = wens;
    pulse_start(8'd2);
    wait_done("lb", d0);
    tick(2);
    check("lb_byte0",   32'(rx_log[w0 % 32]),       32'hA5);
    check("lb_byte1",   32'(rx_log[(w0 + 1) % 32]), 32'h3C);
    check("lb_wens",    wens - w0,                  32'd2);
    check("lb_dones",   dones - d0,                 32'd1);
    check("lb_rises",   rises - r0,                 32'd16);
    check("lb_cs_low",  cs_viol,                    32'd0);
    check("lb_overlap", overlap,                    32'd0);
    check("lb_idle_cs", 32'(cs_n),                  32'd1);

    // ---------------- TX empty stall ----------------
    r0 = rises; d0 = dones; w0 = wens; n0 = rens;
    pulse_start(8'd1);
    tick(20);
    check("st_busy",  32'(busy),  32'd1);
    check("st_cs_n",  32'(cs_n),  32'd0);
    check("st_sclk",  32'(sclk),  32'd0);
    check("st_rises", rises - r0, 32'd0);
    check("st_rens",  rens - n0,  32'd0);
    push(8'h81);
    wait_done("st", d0);
    tick(2);
    check("st_byte",  32'(rx_log[w0 % 32]), 32'h81);
    check("st_wens",  wens - w0,            32'd1);
    check("st_rises2", rises - r0,          32'd8);
    check("st_dones", dones - d0,           32'd1);

    // ---------------- RX full stall at first STORE ----------------
    r0 = rises; d0 = dones; w0 = wens;
    rx_full = 1'b1;
    push(8'hC6); push(8'h19);
    pulse_start(8'd2);
    wait_rises("rf", r0, 8);
    tick(CD + 2);
    tick(10);
    check("rf_no_write", wens - w0,  32'd0);
    check("rf_no_sclk",  rises - r0, 32'd8);
    check("rf_sclk_low", 32'(sclk),  32'd0);
    check("rf_busy",     32'(busy),  32'd1);
    rx_full = 1'b0;
    wait_done("rf", d0);
    tick(2);
    check("rf_byte0", 32'(rx_log[w0 % 32]),       32'hC6);
    check("rf_byte1", 32'(rx_log[(w0 + 1) % 32]), 32'h19);
    check("rf_wens",  wens - w0,                  32'd2);
    check("rf_rises", rises - r0,                 32'd16);

    // ---------------- zero-length request ----------------
    d0 = dones;
    pulse_start(8'd0);
    check("z_busy", 32'(busy), 32'd0);
    check("z_cs_n", 32'(cs_n), 32'd1);
    tick(5);
    check("z_busy2", 32'(busy),  32'd0);
    check("z_dones", dones - d0, 32'd0);

    // ---------------- start while busy ----------------
    r0 = rises; d0 = dones; w0 = wens; p0 = tx_rd;
    push(8'h5A); push(8'hC3);
    pulse_start(8'd2);
    tick(10);
    check("bz_busy", 32'(busy), 32'd1);
    pulse_start(8'd5);
    wait_done("bz", d0);
    tick(300);
    check("bz_dones", dones - d0,                 32'd1);
    check("bz_wens",  wens - w0,                  32'd2);
    check("bz_reads", tx_rd - p0,                 32'd2);
    check("bz_idle",  32'(busy),                  32'd0);
    check("bz_byte0", 32'(rx_log[w0 % 32]),       32'h5A);
    check("bz_byte1", 32'(rx_log[(w0 + 1) % 32]), 32'hC3);
    check("bz_rises", rises - r0,                 32'd16);

    // ---------------- reset mid-SHIFT ----------------
    r0 = rises; w0 = wens; d0 = dones;
    push(8'h11); push(8'h22); push(8'h33);
    pulse_start(8'd3);
    wait_rises("ar", r0, 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("ar_cs_n",   32'(cs_n),    32'd1);
    check("ar_sclk",   32'(sclk),    32'd0);
    check("ar_busy",   32'(busy),    32'd0);
    check("ar_mosi",   32'(mosi),    32'd0);
    check("ar_rxdata", 32'(rx_data), 32'd0);
    check("ar_rx_wen", 32'(rx_wen),  32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("ar_wens",  wens - w0,  32'd0);
    check("ar_dones", dones - d0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_spi_xfer_ctrl
`default_nettype wire
